// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage and imem.
// One request strobe, one response strobe per request.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_valid
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_valid
   );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage and IF/ID register; one outstanding imem request.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus,
   input  logic          stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic [31:0]   ifid_inst,
   output logic [31:0]   ifid_pc,
   output logic [31:0]   ifid_pc4,
   output logic          ifid_valid,
   output logic [6:0]    OpCode,
   output logic [2:0]    Funct3,
   output logic [6:0]    Funct7
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_bubbles
`endif
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_FULL,
      S_DRAIN
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf_inst;
   logic [31:0] r_buf_pc;
   logic [31:0] r_ifid_inst;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_pc4;
   logic        r_ifid_valid;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic [31:0] w_redir_pc;
   logic        w_buf_ld;
   logic        w_word_vld;
   logic [31:0] w_word_inst;
   logic [31:0] w_word_pc;
   logic        w_ifid_ld;
   logic        w_ifid_bub;
   logic        w_outst;

   assign w_redir_pc = redirect_pc & ~32'h3;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_ld    = 1'b0;
      w_word_vld  = 1'b0;
      w_word_inst = r_buf_inst;
      w_word_pc   = r_buf_pc;
      w_outst     = 1'b0;
      case (r_state)
         S_REQ: begin
            w_state_nxt = S_WAIT;
            w_outst     = 1'b1;
         end
         S_WAIT: begin
            w_outst = !bus.imem_valid;
            if (bus.imem_valid) begin
               w_word_vld  = 1'b1;
               w_word_inst = bus.imem_rdata;
               w_word_pc   = r_pc;
               w_pc_nxt    = r_pc + 32'd4;
               w_buf_ld    = stall;
               w_state_nxt = stall ? S_FULL : S_REQ;
            end
         end
         S_FULL: begin
            w_word_vld = 1'b1;
            if (!stall) w_state_nxt = S_REQ;
         end
         S_DRAIN: begin
            w_outst = !bus.imem_valid;
            if (bus.imem_valid) w_state_nxt = S_REQ;
         end
         default: w_state_nxt = S_REQ;
      endcase
      // redirect beats stall; a still-outstanding fetch must be drained
      if (redirect) begin
         w_pc_nxt    = w_redir_pc;
         w_buf_ld    = 1'b0;
         w_word_vld  = 1'b0;
         w_state_nxt = w_outst ? S_DRAIN : S_REQ;
      end
   end

   assign w_ifid_ld  = !redirect && !stall && w_word_vld;
   assign w_ifid_bub = redirect || (!stall && !w_word_vld);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_REQ;
         r_pc         <= RESET_PC;
         r_buf_inst   <= NOP_INST;
         r_buf_pc     <= RESET_PC;
         r_ifid_inst  <= NOP_INST;
         r_ifid_pc    <= RESET_PC;
         r_ifid_pc4   <= RESET_PC + 32'd4;
         r_ifid_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         if (w_buf_ld) begin
            r_buf_inst <= bus.imem_rdata;
            r_buf_pc   <= r_pc;
         end
         if (w_ifid_ld) begin
            r_ifid_inst  <= w_word_inst;
            r_ifid_pc    <= w_word_pc;
            r_ifid_pc4   <= w_word_pc + 32'd4;
            r_ifid_valid <= 1'b1;
         end else if (w_ifid_bub) begin
            r_ifid_inst  <= NOP_INST;
            r_ifid_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] r_perf_fetched;
   logic [31:0] r_perf_bubbles;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_perf_fetched <= 32'd0;
         r_perf_bubbles <= 32'd0;
      end else begin
         if (w_ifid_ld)
            r_perf_fetched <= r_perf_fetched + 32'd1;
         if (w_ifid_bub && !stall)
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
      end
   end

   assign perf_fetched = r_perf_fetched;
   assign perf_bubbles = r_perf_bubbles;
`endif

   assign bus.imem_req  = (r_state == S_REQ) && !rst;
   assign bus.imem_addr = r_pc;

   assign ifid_inst  = r_ifid_inst;
   assign ifid_pc    = r_ifid_pc;
   assign ifid_pc4   = r_ifid_pc4;
   assign ifid_valid = r_ifid_valid;
   assign OpCode     = r_ifid_inst[6:0];
   assign Funct3     = r_ifid_inst[14:12];
   assign Funct7     = r_ifid_inst[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage, RESET_PC = 0x100.
// The bench plays the instruction memory directly from the vector table.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic        ifid_valid;
   logic [6:0]  OpCode;
   logic [2:0]  Funct3;
   logic [6:0]  Funct7;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   int n_chk;
   int n_err;

   fetch_stage_if bus();

   fetch_stage #(
      .RESET_PC(32'h0000_0100),
      .NOP_INST(32'h0000_0013)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .stall      (stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .ifid_inst  (ifid_inst),
      .ifid_pc    (ifid_pc),
      .ifid_pc4   (ifid_pc4),
      .ifid_valid (ifid_valid),
      .OpCode     (OpCode),
      .Funct3     (Funct3),
      .Funct7     (Funct7)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_bubbles(perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        st;
      logic        rd;
      logic [31:0] rpc;
      logic        mv;
      logic [31:0] md;
      logic        ereq;
      logic [31:0] eaddr;
      logic [31:0] einst;
      logic [31:0] epc;
      logic        evld;
   } vec_t;

   vec_t vq[$];

   function automatic void add(
      input logic        r,
      input logic        st,
      input logic        rd,
      input logic [31:0] rpc,
      input logic        mv,
      input logic [31:0] md,
      input logic        ereq,
      input logic [31:0] eaddr,
      input logic [31:0] einst,
      input logic [31:0] epc,
      input logic        evld
   );
      vec_t v;
      v.rst   = r;
      v.st    = st;
      v.rd    = rd;
      v.rpc   = rpc;
      v.mv    = mv;
      v.md    = md;
      v.ereq  = ereq;
      v.eaddr = eaddr;
      v.einst = einst;
      v.epc   = epc;
      v.evld  = evld;
      vq.push_back(v);
   endfunction

   task automatic chk(
      input string       name,
      input int          row,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s row %0d: got %h expected %h",
                  name, row, got, exp);
      end
   endtask

   task automatic step(
      input logic        r,
      input logic        st,
      input logic        rd,
      input logic [31:0] rpc,
      input logic        mv,
      input logic [31:0] md
   );
      @(negedge clk);
      rst            = r;
      stall          = st;
      redirect       = rd;
      redirect_pc    = rpc;
      bus.imem_valid = mv;
      bus.imem_rdata = md;
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      vec_t v;
      logic [31:0] ei;
`ifdef FETCH_PERF_EN
      int exp_f;
      int exp_b;
`endif
      n_chk          = 0;
      n_err          = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = 32'h0;

      // r st rd rpc mv md | req addr inst pc vld
      add(1,0,0,0,0,0, 0,32'h100,NOP,32'h100,0);
      add(1,0,0,0,0,0, 0,32'h100,NOP,32'h100,0);
      add(1,0,0,0,0,0, 0,32'h100,NOP,32'h100,0);
      add(0,0,0,0,0,0, 1,32'h100,NOP,32'h100,0);
      add(0,0,0,0,1,32'h00500093,
          0,32'h100,NOP,32'h100,0);
      add(0,0,0,0,0,0,
          1,32'h104,32'h00500093,32'h100,1);
      add(0,0,0,0,1,32'h00A00113,
          0,32'h104,NOP,32'h100,0);
      add(0,0,0,0,0,0,
          1,32'h108,32'h00A00113,32'h104,1);
      add(0,1,0,0,1,32'h00100193,
          0,32'h108,NOP,32'h104,0);
      add(0,1,0,0,0,0, 0,32'h10C,NOP,32'h104,0);
      add(0,1,0,0,0,0, 0,32'h10C,NOP,32'h104,0);
      add(0,1,0,0,0,0, 0,32'h10C,NOP,32'h104,0);
      add(0,0,0,0,0,0, 0,32'h10C,NOP,32'h104,0);
      add(0,0,0,0,0,0,
          1,32'h10C,32'h00100193,32'h108,1);
      add(0,0,1,32'h200,0,0,
          0,32'h10C,NOP,32'h108,0);
      add(0,0,0,0,0,0, 0,32'h200,NOP,32'h108,0);
      add(0,0,0,0,1,32'hDEADBEEF,
          0,32'h200,NOP,32'h108,0);
      add(0,0,0,0,0,0, 1,32'h200,NOP,32'h108,0);
      add(0,1,1,32'h203,1,32'h12345678,
          0,32'h200,NOP,32'h108,0);
      add(0,0,0,0,0,0, 1,32'h200,NOP,32'h108,0);
      add(0,0,0,0,1,32'h40B50533,
          0,32'h200,NOP,32'h108,0);
      add(0,0,0,0,0,0,
          1,32'h204,32'h40B50533,32'h200,1);
      add(0,0,1,32'hFFFFFFFF,1,32'h11111111,
          0,32'h204,NOP,32'h200,0);
      add(0,0,0,0,0,0,
          1,32'hFFFFFFFC,NOP,32'h200,0);
      add(0,0,0,0,1,32'h0020F1B3,
          0,32'hFFFFFFFC,NOP,32'h200,0);
      add(0,0,1,32'h300,0,0,
          1,32'h0,32'h0020F1B3,32'hFFFFFFFC,1);
      add(0,0,0,0,1,32'hAAAAAAAA,
          0,32'h300,NOP,32'hFFFFFFFC,0);
      add(0,0,0,0,0,0,
          1,32'h300,NOP,32'hFFFFFFFC,0);
      add(1,0,0,0,0,0,
          0,32'h300,NOP,32'hFFFFFFFC,0);
      add(0,0,0,0,0,0, 1,32'h100,NOP,32'h100,0);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         step(v.rst, v.st, v.rd, v.rpc, v.mv, v.md);
         #1;
         ei = v.einst;
         chk("imem_req", i, {31'd0, bus.imem_req},
             {31'd0, v.ereq});
         chk("imem_addr", i, bus.imem_addr, v.eaddr);
         chk("ifid_inst", i, ifid_inst, v.einst);
         chk("ifid_pc", i, ifid_pc, v.epc);
         chk("ifid_pc4", i, ifid_pc4, v.epc + 32'd4);
         chk("ifid_valid", i, {31'd0, ifid_valid},
             {31'd0, v.evld});
         chk("OpCode", i, {25'd0, OpCode},
             {25'd0, ei[6:0]});
         chk("Funct3", i, {29'd0, Funct3},
             {29'd0, ei[14:12]});
         chk("Funct7", i, {25'd0, Funct7},
             {25'd0, ei[31:25]});
      end

`ifdef FETCH_PERF_EN
      step(1,0,0,0,0,0);
      step(1,0,0,0,0,0);
      #1;
      chk("perf_fetched_rst", 100, perf_fetched, 32'd0);
      chk("perf_bubbles_rst", 100, perf_bubbles, 32'd0);
      exp_f = 0;
      exp_b = 0;
      for (int k = 0; k < 10; k++) begin
         step(0,0,0,0,0,0);
         exp_b++;
         step(0,0,0,0,1,32'h00000013 + (k << 7));
         exp_f++;
      end
      step(0,0,1,32'h400,0,0);
      exp_b++;
      step(0,0,0,0,1,32'hBBBBBBBB);
      exp_b++;
      step(0,0,0,0,0,0);
      #1;
      chk("perf_fetched", 101, perf_fetched, exp_f);
      chk("perf_bubbles", 101, perf_bubbles, exp_b);
      chk("perf_addr", 101, bus.imem_addr, 32'h400);
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_chk, n_err);
      $finish;
   end

endmodule
